dac_stream_out: RTL and testbench

Parametrised multi-channel DAC sample driver. It accepts frames of NCH signed samples over a valid/ready stream and buffers them in a frame FIFO. It releases one frame every `rate_div_i+1` clocks to the DAC pins with an aligned write strobe, and handles prefill, underrun recovery and output-code conversion. It sits between the DSP/NCO output stage and the board DAC pads, in the `sys_clk` domain.

---
 rtl/dac_stream_out.sv | 234 +++++++++++++++++++++++
 tb/tb_dac_stream_out.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_out.sv
// dac_stream_out
//   Multi-channel DAC sample driver. Frames of NCH signed samples arrive over a
//   valid/ready stream into a frame FIFO. Once the FIFO holds the requested
//   prefill, one frame is released every rate_div_i+1 clocks onto the DAC pins.
//   The strobe follows the data update by one cycle. An empty FIFO at an update
//   tick is an underrun: the output parks at midscale and the block re-prefills.
//
// Ports
//   sys_clk, rst_n    clock, asynchronous active-low reset
//   en_i              run enable; low flushes the FIFO and parks the outputs
//   rate_div_i        update period minus one (captured in IDLE/PREFILL)
//   prefill_i         frames needed before RUN (0 -> 1, >DEPTH -> DEPTH)
//   s_valid_i/s_ready_o/s_data_i  input frame stream, channel k at [k*DW +: DW]
//   dac_data_o        registered DAC codes
//   dac_wrt_o         per-channel write strobe (all bits identical)
//   running_o         high while releasing frames
//   underrun_o        sticky underrun flag, cleared by en_i=0
//   underrun_cnt_o    saturating underrun counter, cleared by en_i=0
//   level_o           FIFO occupancy in frames
module dac_stream_out #(
  parameter int NCH        = 2,
  parameter int DW         = 14,
  parameter int DEPTH      = 16,
  parameter int OFFSET_BIN = 1
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [15:0]            rate_div_i,
  input  logic [$clog2(DEPTH):0] prefill_i,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [NCH*DW-1:0]      s_data_i,
  output logic [NCH*DW-1:0]      dac_data_o,
  output logic [NCH-1:0]         dac_wrt_o,
  output logic                   running_o,
  output logic                   underrun_o,
  output logic [15:0]            underrun_cnt_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = NCH * DW;

  // One bit set at the MSB of every channel.
  function automatic logic [FW-1:0] msb_mask_f();
    logic [FW-1:0] m;
    m = {FW{1'b0}};
    for (int k = 0; k < NCH; k++) begin
      m[k*DW + DW - 1] = 1'b1;
    end
    return m;
  endfunction

  // Midscale code doubles as the conversion mask: inverting each channel MSB
  // maps two's complement onto offset binary, and an all-zero mask passes through.
  localparam logic [FW-1:0] MID = (OFFSET_BIN != 0) ? msb_mask_f() : {FW{1'b0}};

  function automatic logic [FW-1:0] to_dac_code_f(input logic [FW-1:0] frame);
    return frame ^ MID;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFILL  = 2'd1,
    ST_RUN      = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [FW-1:0]   fifo_mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic [LW-1:0]   pf_eff_s;
  logic [15:0]     rate_div_r;
  logic [15:0]     tick_cnt_r;
  logic            tick_s;
  logic            push_s, pop_s, underrun_evt_s, s_ready_s;
  logic [FW-1:0]   dac_data_r;
  logic            wrt_pend_r;
  logic [NCH-1:0]  dac_wrt_r;
  logic            running_r, underrun_r;
  logic [15:0]     underrun_cnt_r;

  assign s_ready_s      = (level_r < LW'(DEPTH)) && en_i;
  assign s_ready_o      = s_ready_s;
  assign tick_s         = (state_r == ST_RUN) && (tick_cnt_r == rate_div_r);
  assign level_o        = level_r;
  assign dac_data_o     = dac_data_r;
  assign dac_wrt_o      = dac_wrt_r;
  assign running_o      = running_r;
  assign underrun_o     = underrun_r;
  assign underrun_cnt_o = underrun_cnt_r;

  // Effective prefill threshold with the 0 and >DEPTH cases folded in.
  always_comb begin
    pf_eff_s = prefill_i;
    if (prefill_i == LW'(0)) begin
      pf_eff_s = LW'(1);
    end else if (prefill_i > LW'(DEPTH)) begin
      pf_eff_s = LW'(DEPTH);
    end else begin
      pf_eff_s = prefill_i;
    end
  end

  // Next state, FIFO push/pop and underrun detection (level sampled before any write).
  always_comb begin
    push_s         = s_valid_i && s_ready_s;
    pop_s          = 1'b0;
    underrun_evt_s = 1'b0;
    state_nxt_s    = state_r;
    if (!en_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ST_PREFILL;
        ST_PREFILL: begin
          if (level_r >= pf_eff_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_PREFILL;
          end
        end
        ST_RUN: begin
          if (tick_s && (level_r != LW'(0))) begin
            pop_s = 1'b1;
          end else if (tick_s) begin
            underrun_evt_s = 1'b1;
            state_nxt_s    = ST_UNDERRUN;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_UNDERRUN: state_nxt_s = ST_PREFILL;
        default:     state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FIFO storage; contents need no reset because pointers and level do.
  always_ff @(posedge sys_clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= s_data_i;
    end
  end

  // FIFO pointers and occupancy; en_i low flushes.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (!en_i) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Update-period capture and tick counter; the counter only runs in RUN.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_div_r <= 16'd0;
      tick_cnt_r <= 16'd0;
    end else begin
      if ((state_r == ST_IDLE) || (state_r == ST_PREFILL)) begin
        rate_div_r <= rate_div_i;
      end
      if ((state_nxt_s == ST_RUN) && (state_r == ST_RUN) && !tick_s) begin
        tick_cnt_r <= tick_cnt_r + 16'd1;
      end else begin
        tick_cnt_r <= 16'd0;
      end
    end
  end

  // Output registers: data loads the cycle after a tick, strobe one cycle later.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data_r     <= MID;
      wrt_pend_r     <= 1'b0;
      dac_wrt_r      <= {NCH{1'b0}};
      running_r      <= 1'b0;
      underrun_r     <= 1'b0;
      underrun_cnt_r <= 16'd0;
    end else if (!en_i) begin
      dac_data_r     <= MID;
      wrt_pend_r     <= 1'b0;
      dac_wrt_r      <= {NCH{1'b0}};
      running_r      <= 1'b0;
      underrun_r     <= 1'b0;
      underrun_cnt_r <= 16'd0;
    end else begin
      running_r  <= (state_nxt_s == ST_RUN);
      wrt_pend_r <= pop_s;
      dac_wrt_r  <= {NCH{wrt_pend_r}};
      if (pop_s) begin
        dac_data_r <= to_dac_code_f(fifo_mem_r[rd_ptr_r]);
      end else if (underrun_evt_s) begin
        dac_data_r <= MID;
      end
      if (underrun_evt_s) begin
        underrun_r <= 1'b1;
        if (underrun_cnt_r != 16'hFFFF) begin
          underrun_cnt_r <= underrun_cnt_r + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_stream_out.sv
// Self-checking bench for dac_stream_out (NCH=2, DW=14, DEPTH=16).
// Two instances share the stimulus: one offset-binary build and one pass-through
// build. A scoreboard queue holds accepted frames in order; every strobe must
// latch the next frame (the code held on the pins in the cycle before the strobe).
module tb_dac_stream_out;
  localparam int NCH   = 2;
  localparam int DW    = 14;
  localparam int DEPTH = 16;
  localparam int FW    = NCH * DW;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam logic [FW-1:0] MID = {14'h2000, 14'h2000};

  logic           sys_clk, rst_n, en_i, s_valid_i;
  logic [15:0]    rate_div_i;
  logic [LW-1:0]  prefill_i;
  logic [FW-1:0]  s_data_i;
  logic           s_ready_o, running_o, underrun_o;
  logic [FW-1:0]  dac_data_o;
  logic [NCH-1:0] dac_wrt_o;
  logic [15:0]    underrun_cnt_o;
  logic [LW-1:0]  level_o;
  logic           p_s_ready_o, p_running_o, p_underrun_o;
  logic [FW-1:0]  p_dac_data_o;
  logic [NCH-1:0] p_dac_wrt_o;
  logic [15:0]    p_underrun_cnt_o;
  logic [LW-1:0]  p_level_o;

  dac_stream_out #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .OFFSET_BIN(1)) u_dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .en_i(en_i), .rate_div_i(rate_div_i),
    .prefill_i(prefill_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_data_i(s_data_i), .dac_data_o(dac_data_o), .dac_wrt_o(dac_wrt_o),
    .running_o(running_o), .underrun_o(underrun_o),
    .underrun_cnt_o(underrun_cnt_o), .level_o(level_o));

  dac_stream_out #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .OFFSET_BIN(0)) u_dut_pass (
    .sys_clk(sys_clk), .rst_n(rst_n), .en_i(en_i), .rate_div_i(rate_div_i),
    .prefill_i(prefill_i), .s_valid_i(s_valid_i), .s_ready_o(p_s_ready_o),
    .s_data_i(s_data_i), .dac_data_o(p_dac_data_o), .dac_wrt_o(p_dac_wrt_o),
    .running_o(p_running_o), .underrun_o(p_underrun_o),
    .underrun_cnt_o(p_underrun_cnt_o), .level_o(p_level_o));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int            checks, errors, cyc;
  logic [FW-1:0] sbq[$];
  logic [FW-1:0] prev_data, prev_pdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk(input logic [13:0] c0, input logic [13:0] c1);
    return {c1, c0};
  endfunction

  // Offset-binary code of a frame: each channel with its sign bit inverted.
  function automatic logic [FW-1:0] to_offset(input logic [FW-1:0] raw);
    logic [FW-1:0] r;
    logic [DW-1:0] ch;
    r = '0;
    for (int k = 0; k < NCH; k++) begin
      ch = raw[k*DW +: DW];
      ch[DW-1] = ~ch[DW-1];
      r[k*DW +: DW] = ch;
    end
    return r;
  endfunction

  // Scoreboard work done at the falling edge, away from the active edge.
  task automatic monitor();
    if (dac_wrt_o != 2'b00) begin
      chk("wrt_bits_equal", dac_wrt_o, 2'b11);
      chk("pass_wrt_match", p_dac_wrt_o, dac_wrt_o);
      chk("strobe_has_frame", (sbq.size() != 0), 1'b1);
      if (sbq.size() != 0) begin
        chk("dac_code", prev_data, to_offset(sbq[0]));
        chk("pass_code", prev_pdata, sbq[0]);
        void'(sbq.pop_front());
      end
    end
    prev_data  = dac_data_o;
    prev_pdata = p_dac_data_o;
    if (s_valid_i && s_ready_o) sbq.push_back(s_data_i);
    if (!en_i) sbq.delete();
  endtask

  task automatic step();
    @(negedge sys_clk);
    monitor();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  int            rd, run_start, ucyc, n;
  int            wq[$];
  logic [FW-1:0] fa[4];
  logic [LW-1:0] lvl0;

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; en_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
    rate_div_i = 16'd0; prefill_i = '0;
    prev_data = '0; prev_pdata = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_data", dac_data_o, MID);
    chk("rst_pass_data", p_dac_data_o, 28'h0);
    chk("rst_wrt", dac_wrt_o, 2'b00);
    chk("rst_ready", s_ready_o, 1'b0);
    chk("rst_running", running_o, 1'b0);
    chk("rst_underrun", underrun_o, 1'b0);
    chk("rst_ucnt", underrun_cnt_o, 16'd0);
    chk("rst_level", level_o, 5'd0);

    // Basic run: prefill 4, period 4, then underrun.
    rd = 3;
    en_i = 1'b1; prefill_i = 5'd4; rate_div_i = 16'(rd);
    fa[0] = mk(14'h0000, 14'h1FFF);
    fa[1] = mk(14'h2000, 14'h3FFF);
    fa[2] = 28'($urandom);
    fa[3] = 28'($urandom);
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1'b1; s_data_i = fa[i];
      step();
    end
    s_valid_i = 1'b0;
    chk("a_level4", level_o, 5'd4);
    chk("a_not_yet_running", running_o, 1'b0);
    step();
    chk("a_run_entry", running_o, 1'b1);
    run_start = cyc;
    ucyc = -1;
    wq.delete();
    for (int k = 0; k < 40 && ucyc < 0; k++) begin
      step();
      if (dac_wrt_o != 2'b00) begin
        wq.push_back(cyc);
        if (wq.size() == 1) chk("a_first_code", dac_data_o, mk(14'h2000, 14'h3FFF));
        if (wq.size() == 2) chk("a_second_code", dac_data_o, mk(14'h0000, 14'h1FFF));
      end
      if (underrun_o) begin
        ucyc = cyc;
        chk("a_ur_mid", dac_data_o, MID);
        chk("a_ur_cnt", underrun_cnt_o, 16'd1);
        chk("a_ur_not_running", running_o, 1'b0);
      end
    end
    chk("a_underrun_seen", (ucyc >= 0), 1'b1);
    chk("a_strobe_count", wq.size(), 32'd4);
    for (int k = 0; k < wq.size(); k++)
      chk("a_strobe_cycle", wq[k], run_start + rd + 2 + k * (rd + 1));
    chk("a_underrun_cycle", ucyc, run_start + 4 * (rd + 1) + rd + 1);
    step();
    chk("a_prefill_ready", s_ready_o, 1'b1);
    chk("a_prefill_mid", dac_data_o, MID);
    chk("a_prefill_not_running", running_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      s_valid_i = 1'b1; s_data_i = 28'($urandom);
      step();
    end
    s_valid_i = 1'b0;
    for (n = 0; n < 20 && !running_o; n++) step();
    chk("a_resume_running", running_o, 1'b1);
    for (n = 0; n < 100 && underrun_cnt_o != 16'd2; n++) step();
    chk("a_second_underrun", underrun_cnt_o, 16'd2);
    chk("a_sticky", underrun_o, 1'b1);

    // Drop enable mid-RUN at level 7 with a strobe pending.
    prefill_i = 5'd8;
    for (int i = 0; i < 10; i++) begin
      s_valid_i = 1'b1; s_data_i = 28'($urandom);
      step();
    end
    s_valid_i = 1'b0;
    for (n = 0; n < 100 && level_o != 5'd7; n++) step();
    chk("e_level7", level_o, 5'd7);
    chk("e_running", running_o, 1'b1);
    en_i = 1'b0;
    step();
    chk("e_level0", level_o, 5'd0);
    chk("e_mid", dac_data_o, MID);
    chk("e_not_running", running_o, 1'b0);
    chk("e_ucnt_clear", underrun_cnt_o, 16'd0);
    chk("e_ur_clear", underrun_o, 1'b0);
    chk("e_ready_low", s_ready_o, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("e_no_strobe", dac_wrt_o, 2'b00);
      step();
    end

    // Period 0 with a continuous stream: one frame per clock.
    en_i = 1'b1; prefill_i = 5'd4; rate_div_i = 16'd0;
    s_valid_i = 1'b1;
    for (n = 0; n < 20 && !running_o; n++) begin
      s_data_i = 28'($urandom);
      step();
    end
    chk("d_running", running_o, 1'b1);
    for (int k = 0; k < 3; k++) begin
      s_data_i = 28'($urandom);
      step();
    end
    lvl0 = level_o;
    for (int k = 0; k < 20; k++) begin
      s_data_i = 28'($urandom);
      step();
      chk("d_wrt_high", dac_wrt_o, 2'b11);
      chk("d_level_const", level_o, lvl0);
      chk("d_no_underrun", underrun_o, 1'b0);
    end
    s_valid_i = 1'b0;
    for (n = 0; n < 30 && !underrun_o; n++) step();
    chk("d_underrun_after_stop", underrun_cnt_o, 16'd1);
    en_i = 1'b0;
    step();

    // Fill to DEPTH; prefill above DEPTH clamps, ready drops at 16.
    en_i = 1'b1; prefill_i = 5'd20; rate_div_i = 16'd200;
    s_valid_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      s_data_i = 28'($urandom);
      step();
      if (i == 16) chk("b_not_running_at16", running_o, 1'b0);
      if (i == 17) chk("b_running_clamped", running_o, 1'b1);
      if (i >= 16) begin
        chk("b_level_full", level_o, 5'd16);
        chk("b_ready_low", s_ready_o, 1'b0);
      end
    end
    s_valid_i = 1'b0; en_i = 1'b0;
    step();
    chk("b_flushed", level_o, 5'd0);

    // Prefill 0 behaves as 1.
    en_i = 1'b1; prefill_i = 5'd0; rate_div_i = 16'd1;
    repeat (6) step();
    chk("p0_waits", running_o, 1'b0);
    chk("p0_no_underrun", underrun_o, 1'b0);
    s_valid_i = 1'b1; s_data_i = 28'($urandom);
    step();
    s_valid_i = 1'b0;
    chk("p0_level1", level_o, 5'd1);
    step();
    chk("p0_running", running_o, 1'b1);
    for (n = 0; n < 20 && !underrun_o; n++) step();
    chk("p0_underrun", underrun_o, 1'b1);
    en_i = 1'b0;
    step();

    // Randomised traffic against the scoreboard.
    for (int r = 0; r < 3; r++) begin
      en_i = 1'b1;
      prefill_i = 5'($urandom_range(1, 6));
      rate_div_i = 16'($urandom_range(0, 3));
      for (int k = 0; k < 300; k++) begin
        s_valid_i = ($urandom_range(0, 9) < 6);
        s_data_i = 28'($urandom);
        step();
      end
      s_valid_i = 1'b0;
      prefill_i = 5'd1;
      repeat (100) step();
      chk("r_scoreboard_drained", sbq.size(), 32'd0);
      chk("r_level_empty", level_o, 5'd0);
      en_i = 1'b0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
